fp16_mul_arbiter: RTL

- Round-robin arbiter and sequencer that shares one combinational half-precision (FP16) multiplier among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and registers the winner's operands onto the shared multiplier inputs.
- Captures the product one cycle later and holds it in a per-requester response register until that requester drains it.
- Sits between the FP16 compute clients and the single FP16 multiplier instance in the datapath.

---
 rtl/fp16_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/fp16_mul_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared FP16 definitions for the multiplier arbiter: field positions, widths,
// issue-stage state encoding and a slice helper for flattened operand buses.
package fp16_pkg;

  localparam int FP16_W   = 16;
  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 10;
  localparam int MANT_MSB = 9;

  localparam int MAX_REQ  = 8;
  localparam int BUS_W    = MAX_REQ * FP16_W;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CAPTURE = 1'b1
  } issue_state_e;

  // Bus is zero-extended to the maximum requester count so one helper serves any NREQ.
  function automatic logic [FP16_W-1:0] fp16_slice(input logic [BUS_W-1:0] bus,
                                                   input int               idx);
    return bus[idx*FP16_W +: FP16_W];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or above the
// pointer (modulo NREQ) wins; returns a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_elig,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(i_ptr) + k) % NREQ);
      if (i_elig[w_idx] && !o_any) begin
        o_gnt[w_idx] = 1'b1;
        o_idx        = w_idx;
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Shares one combinational FP16 multiplier among NREQ requesters: round-robin
// grant, registered operands, product captured one cycle later into per-requester slots.
module fp16_mul_arbiter
  import fp16_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*FP16_W-1:0] req_a,
  input  logic [NREQ*FP16_W-1:0] req_b,
  output logic [FP16_W-1:0]      mul_a,
  output logic [FP16_W-1:0]      mul_b,
  input  logic [FP16_W-1:0]      mul_p,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [NREQ*FP16_W-1:0] rsp_data,
  output logic                   busy,
  output logic [15:0]            op_count
);

  // Handshakes: a transfer happens on an edge where valid and ready are both high.
  // req_ready is combinational and one-hot; rsp_valid holds until rsp_ready is seen.

  issue_state_e          r_state;
  logic [IDW-1:0]        r_ptr;
  logic [IDW-1:0]        r_tag;
  logic [NREQ-1:0]       r_pend;
  logic [NREQ-1:0]       r_rsp_valid;
  logic [NREQ*FP16_W-1:0] r_rsp_data;
  logic [FP16_W-1:0]     r_mul_a;
  logic [FP16_W-1:0]     r_mul_b;
  logic [15:0]           r_op_count;

  logic [NREQ-1:0]       w_elig;
  logic [NREQ-1:0]       w_gnt;
  logic [IDW-1:0]        w_gnt_idx;
  logic                  w_any;
  logic [NREQ-1:0]       w_cap_mask;
  logic [BUS_W-1:0]      w_req_a_ext;
  logic [BUS_W-1:0]      w_req_b_ext;

  // A requester whose response slot is being drained this cycle may issue again.
  assign w_elig = req_valid & ~r_pend & (~r_rsp_valid | rsp_ready) & {NREQ{~rst}};

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .i_elig (w_elig),
    .i_ptr  (r_ptr),
    .o_gnt  (w_gnt),
    .o_idx  (w_gnt_idx),
    .o_any  (w_any)
  );

  always_comb begin
    w_req_a_ext = '0;
    w_req_b_ext = '0;
    w_req_a_ext[NREQ*FP16_W-1:0] = req_a;
    w_req_b_ext[NREQ*FP16_W-1:0] = req_b;
  end

  always_comb begin
    w_cap_mask = '0;
    if (r_state == ST_CAPTURE) w_cap_mask[r_tag] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_tag       <= '0;
      r_pend      <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_op_count  <= '0;
    end else begin
      r_pend      <= (r_pend & ~w_cap_mask) | w_gnt;
      // Capture wins over drain when both hit the same slot on one edge.
      r_rsp_valid <= (r_rsp_valid & ~rsp_ready) | w_cap_mask;
      if (r_state == ST_CAPTURE) begin
        r_rsp_data[int'(r_tag)*FP16_W +: FP16_W] <= mul_p;
        r_op_count <= r_op_count + 16'd1;
      end
      if (w_any) begin
        r_state <= ST_CAPTURE;
        r_tag   <= w_gnt_idx;
        r_mul_a <= fp16_slice(w_req_a_ext, int'(w_gnt_idx));
        r_mul_b <= fp16_slice(w_req_b_ext, int'(w_gnt_idx));
        r_ptr   <= (w_gnt_idx == IDW'(NREQ-1)) ? '0 : w_gnt_idx + 1'b1;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign req_ready = w_gnt;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state == ST_CAPTURE);
  assign op_count  = r_op_count;

endmodule
